// File: rtl/dma_pkg.sv
// dma_pkg: AXI3 burst constants and state types shared by the DMA reader and writer.
// Holds the fixed 16-beat x 64-bit INCR burst shape, the OKAY response code and the default HP0 buffer.
package dma_pkg;
    localparam logic [3:0]  BURST_LEN       = 4'd15;
    localparam logic [2:0]  BEAT_SIZE       = 3'd3;
    localparam logic [1:0]  BURST_INC       = 2'b01;
    localparam logic [31:0] BYTES_PER_BURST = 32'd128;
    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [31:0] HP0_BASE        = 32'h1000_0000;
    localparam logic [31:0] HP0_SIZE        = 32'h000C_3500;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_SPACE, S_ADDR, S_DATA, S_DONE} rd_state_e;
endpackage

// File: rtl/dma_reader_if.sv
// dma_reader_if: AXI3 read address and read data channels of the HP0 port.
// master: drives araddr/arvalid/arlen/arsize/arburst/rready; slave: drives arready/rdata/rvalid/rresp/rlast.
interface dma_reader_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [63:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic        rlast;
    modport master (output araddr, arvalid, arlen, arsize, arburst, rready,
                    input  arready, rdata, rvalid, rresp, rlast);
    modport slave  (input  araddr, arvalid, arlen, arsize, arburst, rready,
                    output arready, rdata, rvalid, rresp, rlast);
endinterface

// File: rtl/posedge_detector.sv
// posedge_detector: one-cycle pulse on each rising edge of a level input.
// Ports: clk, rst (sync, active-high), i_sig level in, o_edge pulse out.
module posedge_detector (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_edge
);
    logic r_prev;
    always_ff @(posedge clk) r_prev <= rst ? 1'b0 : i_sig;
    assign o_edge = i_sig && !r_prev;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count and synchronous flush.
// Ports: clk, rst, i_flush, i_push/i_data write side, i_pop read side, o_data head word, o_empty, o_count occupancy.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    assign w_pop = i_pop && !o_empty;
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= i_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_pop};
        end
    end
    always_ff @(posedge clk) if (i_push) r_mem[r_wptr] <= i_data;
    assign o_data  = r_mem[r_rptr];
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    // DEPTH is a power of two, so the top count bit alone means full.
    assert property (@(posedge clk) disable iff (rst) !(i_push && !w_pop && r_count[AW]));
endmodule

// File: rtl/dma_reader.sv
// dma_reader: AXI3 read-burst master streaming a contiguous DDR buffer out through a beat FIFO.
// Ports: aclk, rst_i (sync, active-high); m_axi AR/R channels; start_i (rising edge), abort_i (level);
// data_o/valid_o/ready_i sample stream; busy_o, done_o, error_o (sticky) status; level_o FIFO occupancy.
// Macro DMA_READER_LOOP_EN: wrap to BASE_ADDR after the final burst with a one-cycle done_o pulse.
module dma_reader
    import dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = HP0_BASE,
    parameter int          NUM_BURSTS = int'(HP0_SIZE / BYTES_PER_BURST),
    parameter int          FIFO_DEPTH = 32
) (
    input  logic                        aclk,
    input  logic                        rst_i,
    dma_reader_if.master                m_axi,
    input  logic                        start_i,
    input  logic                        abort_i,
    output logic [63:0]                 data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);
`ifdef DMA_READER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam int BW = $clog2(NUM_BURSTS + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    rd_state_e     r_state, w_next;
    logic [31:0]   r_addr;
    logic [BW-1:0] r_burst_cnt;
    logic [3:0]    r_beat;
    logic          r_start_q, r_done, r_error;
    logic          w_edge, w_start, w_beat, w_burst_end, w_last, w_wrap, w_beat_err, w_empty;
    posedge_detector u_start (.clk(aclk), .rst(rst_i), .i_sig(r_start_q), .o_edge(w_edge));
    sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(aclk), .rst(rst_i), .i_flush(w_start), .i_push(w_beat), .i_data(m_axi.rdata),
        .i_pop(ready_i), .o_data(data_o), .o_empty(w_empty), .o_count(level_o)
    );
    assign w_start     = w_edge && (r_state == S_IDLE || r_state == S_DONE);
    assign w_beat      = r_state == S_DATA && m_axi.rvalid;
    assign w_burst_end = w_beat && r_beat == BURST_LEN;
    assign w_last      = r_burst_cnt == BW'(NUM_BURSTS - 1);
    assign w_wrap      = w_burst_end && w_last && LOOP;
    assign w_beat_err  = w_beat && (m_axi.rresp != RESP_OKAY || m_axi.rlast != (r_beat == BURST_LEN));
    always_ff @(posedge aclk) r_state <= rst_i ? S_IDLE : w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_start ? S_WAIT_SPACE : r_state;
            // Room for a full burst up front lets rready stay high for the whole burst.
            S_WAIT_SPACE:   w_next = level_o <= LW'(FIFO_DEPTH - 16) ? S_ADDR : S_WAIT_SPACE;
            S_ADDR:         w_next = m_axi.arready ? S_DATA : S_ADDR;
            S_DATA:         w_next = !w_burst_end ? S_DATA : (w_last && !LOOP) ? S_DONE :
                                     abort_i ? S_IDLE : S_WAIT_SPACE;
            default:        w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (rst_i) begin
            r_start_q   <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_burst_cnt <= '0;
            r_beat      <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_start_q   <= start_i;
            r_addr      <= (w_start || w_wrap) ? BASE_ADDR : w_burst_end ? r_addr + BYTES_PER_BURST : r_addr;
            r_burst_cnt <= (w_start || w_wrap) ? '0 : w_burst_end ? r_burst_cnt + 1'b1 : r_burst_cnt;
            r_beat      <= (r_state == S_ADDR && m_axi.arready) ? 4'd0 : w_beat ? r_beat + 4'd1 : r_beat;
            // In loop mode done_o only marks the wrap for a single cycle.
            r_done      <= w_start ? 1'b0 : (w_burst_end && w_last) ? 1'b1 : LOOP ? 1'b0 : r_done;
            r_error     <= w_start ? 1'b0 : r_error || w_beat_err;
        end
    end
    assign m_axi.araddr  = r_addr;
    assign m_axi.arvalid = r_state == S_ADDR;
    assign m_axi.arlen   = BURST_LEN;
    assign m_axi.arsize  = BEAT_SIZE;
    assign m_axi.arburst = BURST_INC;
    assign m_axi.rready  = r_state == S_DATA;
    assign valid_o       = !w_empty;
    assign busy_o        = r_state == S_WAIT_SPACE || r_state == S_ADDR || r_state == S_DATA;
    assign done_o        = r_done;
    assign error_o       = r_error;
endmodule

// File: tb/tb_dma_reader.sv
// tb_dma_reader: randomized memory responder plus queue model checking the dma_reader beat stream and status.
module tb_dma_reader;
    localparam int          NB    = 4;
    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    logic        clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
    logic [63:0] data_o;
    logic        valid_o, busy_o, done_o, error_o;
    logic [5:0]  level_o;
    dma_reader_if m_axi();
    dma_reader #(.BASE_ADDR(BASE), .NUM_BURSTS(NB), .FIFO_DEPTH(DEPTH)) dut (
        .aclk(clk), .rst_i(rst_i), .m_axi(m_axi), .start_i(start_i), .abort_i(abort_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o), .level_o(level_o)
    );
    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [63:0] q[$];
    logic [63:0] first_out;
    logic [31:0] ar_log [16];
    logic [31:0] stall_addr;
    logic        exp_err = 1'b0, err_en = 1'b1, stalled = 1'b0;
    int          mbeat = 0, pass_ar = 0, beats_out = 0, ar_log_n = 0;
    int          stall_len = 0, stall_max = 0, done_cnt = 0, done_run = 0, done_max = 0;
    int          rv_pct = 100, rdy_pct = 100, ar_delay = 0;
    int          inj_resp_burst = -1, inj_resp_beat = -1, inj_last_burst = -1, inj_last_beat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory side: answers each AR with 16 beats whose data encodes the beat address.
    initial begin : responder
        logic        hs_ar, hs_r, rs, act;
        logic [31:0] a, rbase, ba;
        int          rbeat, ar_wait, bidx;
        act = 1'b0; rbase = BASE; rbeat = 0; ar_wait = 0;
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = 2'b00; m_axi.rlast = 1'b0;
        forever begin
            @(negedge clk);
            rs    = rst_i;
            hs_ar = m_axi.arvalid && m_axi.arready;
            hs_r  = m_axi.rvalid && m_axi.rready;
            a     = m_axi.araddr;
            if (!rs && m_axi.arvalid && !hs_ar) ar_wait++;
            @(posedge clk);
            #1;
            if (rs) begin
                act = 1'b0; rbeat = 0; ar_wait = 0;
            end else begin
                if (hs_ar) begin act = 1'b1; rbeat = 0; rbase = a; ar_wait = 0; end
                if (hs_r) begin rbeat++; if (rbeat == 16) act = 1'b0; end
            end
            bidx          = int'((rbase - BASE) >> 7);
            ba            = rbase + 32'(8 * rbeat);
            m_axi.arready = ar_wait >= ar_delay;
            m_axi.rvalid  = act && ($urandom_range(0, 99) < rv_pct);
            m_axi.rdata   = {~ba, ba};
            m_axi.rresp   = (bidx == inj_resp_burst && rbeat == inj_resp_beat) ? 2'b10 : 2'b00;
            m_axi.rlast   = rbeat == 15 || (bidx == inj_last_burst && rbeat == inj_last_beat);
            ready_i       = $urandom_range(0, 99) < rdy_pct;
        end
    end

    // Compare process: outputs against the queue model, then apply the handshakes of the coming edge.
    always @(negedge clk) begin
        chk("level", 64'(level_o), 64'(q.size()));
        chk("valid", valid_o, q.size() != 0);
        if (valid_o && q.size() != 0) chk("data", data_o, q[0]);
        if (err_en) chk("error", error_o, exp_err);
        if (m_axi.arvalid) begin
            chk("ar_space", q.size() <= DEPTH - 16, 1'b1);
            chk("araddr", m_axi.araddr, BASE + 32'(128 * (pass_ar % NB)));
        end
        if (stalled) begin
            chk("ar_hold_valid", m_axi.arvalid, 1'b1);
            chk("ar_hold_addr", m_axi.araddr, stall_addr);
        end
        if (done_o) begin
            done_cnt++; done_run++;
            if (done_run > done_max) done_max = done_run;
        end else done_run = 0;
        if (rst_i) begin
            q.delete(); mbeat = 0; stalled = 1'b0; exp_err = 1'b0;
        end else begin
            stalled    = m_axi.arvalid && !m_axi.arready;
            stall_addr = m_axi.araddr;
            stall_len  = stalled ? stall_len + 1 : 0;
            if (stall_len > stall_max) stall_max = stall_len;
            if (m_axi.arvalid && m_axi.arready) begin
                if (ar_log_n < 16) ar_log[ar_log_n] = m_axi.araddr;
                ar_log_n++; pass_ar++;
            end
            if (valid_o && ready_i && q.size() != 0) begin
                if (beats_out == 0) first_out = q[0];
                void'(q.pop_front()); beats_out++;
            end
            if (m_axi.rvalid && m_axi.rready) begin
                q.push_back(m_axi.rdata);
                if (m_axi.rresp != 2'b00 || m_axi.rlast != (mbeat == 15)) exp_err = 1'b1;
                mbeat = (mbeat + 1) % 16;
            end
            chk("no_overflow", q.size() <= DEPTH, 1'b1);
        end
    end

    task automatic start_pass();
        int n = 0;
        err_en = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        do begin @(negedge clk); n++; end while (!busy_o && n < 20);
        chk("start_busy", busy_o, 1'b1);
        exp_err = 1'b0; pass_ar = 0; beats_out = 0; err_en = 1'b1; start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy_o || level_o != 0) && n < budget);
        chk("idle_timeout", n < budget, 1'b1);
    endtask

    task automatic wait_ar(input int cnt);
        int n = 0;
        while (pass_ar < cnt && n < 3000) begin @(negedge clk); n++; end
        chk("ar_timeout", n < 3000, 1'b1);
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_arvalid", m_axi.arvalid, 1'b0);
        chk("rst_rready", m_axi.rready, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_araddr", m_axi.araddr, 32'h1000_0000);
        chk("arlen", m_axi.arlen, 4'd15);
        chk("arsize", m_axi.arsize, 3'd3);
        chk("arburst", m_axi.arburst, 2'b01);
`ifdef DMA_READER_LOOP_EN
        ar_log_n = 0; done_cnt = 0; done_max = 0;
        start_pass();
        wait_ar(NB + 2);
        abort_i = 1'b1;
        wait_idle(3000);
        abort_i = 1'b0;
        chk("lp_wrap", ar_log[NB], 32'h1000_0000);
        chk("lp_next", ar_log[NB + 1], 32'h1000_0080);
        chk("lp_done_len", 64'(done_max), 64'd1);
        chk("lp_done_cnt", 64'(done_cnt), 64'd1);
        chk("lp_beats", 64'(beats_out), 64'd96);
        chk("lp_busy", busy_o, 1'b0);
`else
        ar_log_n = 0;
        start_pass();
        wait_idle(3000);
        chk("p1_ar0", ar_log[0], 32'h1000_0000);
        chk("p1_ar1", ar_log[1], 32'h1000_0080);
        chk("p1_ar2", ar_log[2], 32'h1000_0100);
        chk("p1_ar3", ar_log[3], 32'h1000_0180);
        chk("p1_ar_n", 64'(ar_log_n), 64'd4);
        chk("p1_beats", 64'(beats_out), 64'd64);
        chk("p1_first", first_out, 64'hEFFF_FFFF_1000_0000);
        chk("p1_done", done_o, 1'b1);
        chk("p1_error", error_o, 1'b0);

        rdy_pct = 0; rv_pct = 70;
        start_pass();
        repeat (200) @(negedge clk);
        chk("bp_ar", 64'(pass_ar), 64'd2);
        chk("bp_level", 64'(level_o), 64'd32);
        chk("bp_arvalid", m_axi.arvalid, 1'b0);
        rdy_pct = 100;
        wait_idle(3000);
        chk("bp_beats", 64'(beats_out), 64'd64);
        chk("bp_done", done_o, 1'b1);

        rv_pct = 100; inj_resp_burst = 1; inj_resp_beat = 5;
        start_pass();
        wait_idle(3000);
        chk("resp_error", error_o, 1'b1);
        chk("resp_done", done_o, 1'b1);
        chk("resp_beats", 64'(beats_out), 64'd64);
        inj_resp_burst = -1; inj_last_burst = 2; inj_last_beat = 7;
        start_pass();
        wait_idle(3000);
        chk("rlast_error", error_o, 1'b1);
        chk("rlast_done", done_o, 1'b1);
        inj_last_burst = -1;

        for (int p = 0; p < 3; p++) begin
            rv_pct = $urandom_range(30, 100); rdy_pct = $urandom_range(20, 100); ar_delay = $urandom_range(0, 3);
            start_pass();
            wait_idle(6000);
            chk("rnd_beats", 64'(beats_out), 64'd64);
            chk("rnd_done", done_o, 1'b1);
        end
        rv_pct = 100; rdy_pct = 100;

        ar_delay = 10; stall_max = 0;
        start_pass();
        wait_idle(3000);
        chk("ard_stall", 64'(stall_max), 64'd10);
        chk("ard_beats", 64'(beats_out), 64'd64);
        ar_delay = 0;

        rdy_pct = $urandom_range(30, 100);
        start_pass();
        wait_ar(3);
        abort_i = 1'b1;
        wait_idle(3000);
        repeat (30) @(negedge clk);
        chk("ab_ar", 64'(pass_ar), 64'd3);
        chk("ab_beats", 64'(beats_out), 64'd48);
        chk("ab_busy", busy_o, 1'b0);
        chk("ab_done", done_o, 1'b0);
        chk("ab_arvalid", m_axi.arvalid, 1'b0);
        abort_i = 1'b0; rdy_pct = 100;

        start_pass();
        n = 0;
        while (!(pass_ar == 2 && mbeat == 9) && n < 3000) begin @(negedge clk); n++; end
        chk("rs_reach", n < 3000, 1'b1);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rs_arvalid", m_axi.arvalid, 1'b0);
        chk("rs_rready", m_axi.rready, 1'b0);
        chk("rs_valid", valid_o, 1'b0);
        chk("rs_busy", busy_o, 1'b0);
        chk("rs_done", done_o, 1'b0);
        chk("rs_error", error_o, 1'b0);
        chk("rs_level", 64'(level_o), 64'd0);
        ar_log_n = 0;
        start_pass();
        wait_idle(3000);
        chk("rs_ar0", ar_log[0], 32'h1000_0000);
        chk("rs_beats", 64'(beats_out), 64'd64);
        chk("rs_done2", done_o, 1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
